// File: rtl/solver_output_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM write port among tile solvers.
// Optional ARB_STATS_EN adds write and stall counters.
module solver_output_arbiter #(
    parameter int NUM_SOLVERS = 4,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 16,
    parameter int BURST_MAX   = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_SOLVERS-1:0]           req_valid,
    input  logic [NUM_SOLVERS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_SOLVERS*DATA_BITS-1:0] req_data,
    output logic [NUM_SOLVERS-1:0]           req_ack,
    output logic                             mem_write,
    output logic [ADDR_BITS-1:0]             mem_address,
    output logic [DATA_BITS-1:0]             mem_writedata,
    input  logic                             mem_waitrequest,
    output logic                             busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]                      stat_writes,
    output logic [31:0]                      stat_stall_cycles
`endif
);

    localparam int GW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {ARB, WRITE} state_t;

    state_t               state, state_next;
    logic [GW-1:0]        rr_ptr, rr_ptr_next;
    logic [GW-1:0]        grant, grant_next;
    logic [CW-1:0]        burst_count, burst_next;
    logic                 active, active_next;
    logic                 write_next;
    logic [ADDR_BITS-1:0] address_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 accept;

    assign accept = mem_write && !mem_waitrequest;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ARB;
            rr_ptr        <= '0;
            grant         <= '0;
            burst_count   <= '0;
            active        <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_ptr_next;
            grant         <= grant_next;
            burst_count   <= burst_next;
            active        <= active_next;
            mem_write     <= write_next;
            mem_address   <= address_next;
            mem_writedata <= data_next;
        end
    end

    always_comb begin
        int            idx;
        logic          found;
        logic [GW-1:0] sel;
        idx          = 0;
        found        = 1'b0;
        sel          = grant;
        state_next   = state;
        rr_ptr_next  = rr_ptr;
        grant_next   = grant;
        burst_next   = burst_count;
        active_next  = active;
        write_next   = mem_write;
        address_next = mem_address;
        data_next    = mem_writedata;
        unique case (state)
            ARB: begin
                // An active burst keeps the grantee until it runs dry or hits the cap.
                if (active && req_valid[grant] && burst_count < CW'(BURST_MAX)) begin
                    found = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_SOLVERS; i++) begin
                        idx = int'(rr_ptr) + i;
                        if (idx >= NUM_SOLVERS) idx = idx - NUM_SOLVERS;
                        if (!found && req_valid[idx]) begin
                            found = 1'b1;
                            sel   = GW'(idx);
                        end
                    end
                    if (found) begin
                        grant_next  = sel;
                        rr_ptr_next = (sel == GW'(NUM_SOLVERS - 1)) ? '0 : sel + 1'b1;
                        burst_next  = '0;
                    end
                end
                active_next = found;
                write_next  = found;
                if (found) begin
                    address_next = req_addr[int'(sel)*ADDR_BITS +: ADDR_BITS];
                    data_next    = req_data[int'(sel)*DATA_BITS +: DATA_BITS];
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                if (!mem_waitrequest) begin
                    write_next = 1'b0;
                    burst_next = burst_count + 1'b1;
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        busy    = (state == WRITE);
        req_ack = '0;
        if (accept) req_ack[grant] = 1'b1;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (accept) stat_writes <= stat_writes + 32'd1;
            if (mem_write && mem_waitrequest)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/solver_output_arbiter.md
Name: solver_output_arbiter

Overview:
- Shares one Avalon-MM style memory write port among NUM_SOLVERS tile solvers.
- Each solver presents per-pixel results: an iteration count and its frame-buffer address.
- The arbiter grants solvers round-robin and issues each write, holding it through waitrequest. It acknowledges the solver once memory accepts the word.
- Bounded bursts keep one solver from starving the others. Sits between the tile_solver array and the SDRAM/frame-buffer write master.

Parameters:
- NUM_SOLVERS, 4, number of requesting solvers (1..256).
- ADDR_BITS, 32, memory address width.
- DATA_BITS, 16, result word width (iteration count).
- BURST_MAX, 8, max consecutive accepted writes per grant before forced rotation (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NUM_SOLVERS  solver i has a result word pending.
- req_addr  in  NUM_SOLVERS*ADDR_BITS  solver i address at [i*ADDR_BITS +: ADDR_BITS].
- req_data  in  NUM_SOLVERS*DATA_BITS  solver i data at [i*DATA_BITS +: DATA_BITS].
- req_ack  out  NUM_SOLVERS  one-cycle pulse on bit g when solver g's word is accepted by memory.
- mem_write  out  1  write request to memory.
- mem_address  out  ADDR_BITS  write address.
- mem_writedata  out  DATA_BITS  write data.
- mem_waitrequest  in  1  memory stall; a write is accepted on a cycle with mem_write=1 and mem_waitrequest=0.
- busy  out  1  high whenever state is WRITE.

Behaviour:
- Reset (async): state=ARB, rr_ptr=0, grant=0, burst_count=0, mem_write=0, mem_address=0, mem_writedata=0, busy=0. req_ack=0 because it is derived from mem_write. A write in flight at reset is dropped, with no ack.
- Registered internal state: state, rr_ptr, grant, burst_count.
- Registered outputs: mem_write, mem_address, mem_writedata.
- ARB state, per cycle:
  - If grant has been held this burst, req_valid[grant]=1 and burst_count<BURST_MAX: keep grant.
  - Otherwise, rotate. The candidate search starts at rr_ptr and wraps NUM_SOLVERS-1 -> 0. Pick the first index with req_valid set, set grant to it, set rr_ptr=(grant+1) mod NUM_SOLVERS, and set burst_count=0.
  - On a selection: latch req_addr/req_data of grant into mem_address/mem_writedata, set mem_write=1, go to WRITE.
  - No request: remain in ARB, mem_write=0.
- WRITE state:
  - Hold mem_write, mem_address and mem_writedata stable while mem_waitrequest=1, with no timeout.
  - On accept (mem_waitrequest=0): req_ack[grant]=1 combinationally in that cycle. Next cycle mem_write=0, burst_count increments, return to ARB.
- Throughput: at most one write per 2 cycles (ARB bubble). Latency from req_valid rise (arbiter idle) to mem_write=1 is 1 cycle.
- Solver contract: hold valid/addr/data until ack, then present the next word or drop valid in the cycle after ack.
  - Address and data are captured at grant, so a solver dropping req_valid mid-WRITE does not corrupt the write. The write still completes and is acked.
- Burst end: a burst ends when burst_count reaches BURST_MAX or when the grantee has no valid request in ARB. Rotation then begins at rr_ptr.
- BURST_MAX=1 gives pure round-robin.
- NUM_SOLVERS=1 gives grant fixed at 0 and rr_ptr always 0.
- Simultaneous requests resolve purely by rr_ptr order, with no fixed priority.
- All-zero req_valid leaves the arbiter idle indefinitely.

Optional Feature:
- Macro ARB_STATS_EN. When defined, adds output ports:
  - stat_writes (32 bit): increments on every accepted write.
  - stat_stall_cycles (32 bit): increments on every cycle with mem_write=1 and mem_waitrequest=1.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Single requester: NUM_SOLVERS=4, req_valid=4'b0100, addr=0x1000, data=0x00FF, waitrequest=0 -> mem_write=1 one cycle after request with address 0x1000 and data 0x00FF; req_ack=4'b0100 in that cycle; mem_write=0 next cycle.
- Fair rotation: BURST_MAX=1, req_valid=4'b1111 held, each solver re-presenting after ack -> grant order 0,1,2,3,0,..., one ack every 2 cycles.
- Burst limit: BURST_MAX=8, solver 1 continuously valid, solver 3 also valid -> exactly 8 acks to solver 1, then solver 3 is granted.
- Stall: hold waitrequest=1 for 5 cycles during a write of addr 0x2004 -> address and data stable for all 5 cycles, no ack until the cycle waitrequest=0, then exactly one ack pulse.
- Wrap-around: rr_ptr=3 after granting solver 2, req_valid=4'b0011 -> solver 0 granted next, then solver 1.
- Async reset mid-WRITE with waitrequest=1 -> mem_write=0 before the next clock edge, no ack, arbiter idle in ARB. With ARB_STATS_EN, both counters read 0 after reset.
